// File: rtl/spmv_pkg.sv
// Shared SpMV constants and the result-writer state encoding.
package spmv_pkg;

  localparam int unsigned RESULT_W = 256;
  localparam int unsigned LANE_W   = 16;
  localparam int unsigned LANES    = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE
  } wr_state_t;

  // Row counts above the lane count saturate at LANES.
  function automatic logic [4:0] clamp_rows(input logic [7:0] row_count);
    return (row_count > 8'd16) ? 5'd16 : row_count[4:0];
  endfunction

endpackage

// File: rtl/spmv_lane_mask.sv
// Zeroes every result lane at or above the valid row count.
module spmv_lane_mask
  import spmv_pkg::*;
(
  input  logic [4:0]          rows,
  input  logic [RESULT_W-1:0] vec,
  output logic [RESULT_W-1:0] masked
);

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (i < 32'(rows)) masked[i*LANE_W +: LANE_W] = vec[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/spmv_result_writer.sv
// Streams the valid lanes of an SpMV result vector to SRAM in DATA_W-bit beats.
module spmv_result_writer
  import spmv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_result_valid,
  input  logic [RESULT_W-1:0] i_result,
  input  logic [7:0]          i_row_count,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic                i_wr_ready,
  output logic                o_wr_en,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_drop
);

  localparam int unsigned L  = DATA_W / LANE_W;
  localparam int unsigned N  = RESULT_W / DATA_W;
  localparam int unsigned BW = $clog2(N + 1);

  wr_state_t           state;
  logic [RESULT_W-1:0] buffer;
  logic [RESULT_W-1:0] masked;
  logic [4:0]          rows;
  logic [4:0]          rows_in;
  logic [ADDR_W-1:0]   base;
  logic [BW-1:0]       beats;
  logic [BW-1:0]       beat_count;
  logic [BW-1:0]       idx;
  logic [BW-1:0]       idx_next;

  assign rows_in    = clamp_rows(i_row_count);
  assign beat_count = BW'((32'(rows) + L - 1) / L);
  assign idx_next   = idx + BW'(1);

  spmv_lane_mask u_mask (
    .rows   (rows_in),
    .vec    (i_result),
    .masked (masked)
  );

  // Beat outputs are preloaded one cycle ahead so they come only from registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      buffer    <= '0;
      rows      <= '0;
      base      <= '0;
      beats     <= '0;
      idx       <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_drop <= i_result_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (i_result_valid) begin
            buffer <= masked;
            rows   <= rows_in;
            base   <= i_base_addr;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          beats <= beat_count;
          if (rows == 5'd0) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end else begin
            o_wr_en   <= 1'b1;
            o_wr_addr <= base;
            o_wr_data <= buffer[DATA_W-1:0];
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (o_wr_en && i_wr_ready) begin
            if (idx == beats - BW'(1)) begin
              o_wr_en <= 1'b0;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              state   <= DONE;
            end else begin
              idx       <= idx_next;
              o_wr_addr <= base + ADDR_W'(idx_next);
              o_wr_data <= buffer[idx_next*DATA_W +: DATA_W];
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
